// File: rtl/stopwatch_pkg.sv
// Shared types and digit constants for the MM:SS stopwatch.
// The helper names the 59 boundary so the top-level never hard-codes it.
package stopwatch_pkg;

  localparam int DIGIT_W  = 4;
  localparam int TENS_MAX = 5;
  localparam int ONES_MAX = 9;

  typedef enum logic {
    RUN    = 1'b0,
    PAUSED = 1'b1
  } run_state_e;

  // True when a tens/ones pair reads 59, the last value before wrapping.
  function automatic logic bcd_is_max(input logic [DIGIT_W-1:0] tens,
                                      input logic [DIGIT_W-1:0] ones);
    return (tens == DIGIT_W'(TENS_MAX)) && (ones == DIGIT_W'(ONES_MAX));
  endfunction

endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD counter 00..59. It steps on inc, and carry flags the 59->00 wrap.
module bcd_mod60
  import stopwatch_pkg::*;
(
  input  logic               clk,
  input  logic               rstB,
  input  logic               inc,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] ones,
  output logic               carry
);

  logic w_at_max;

  assign w_at_max = bcd_is_max(tens, ones);
  assign carry    = inc & w_at_max;

  // The >= compares pull any out-of-range digit back to a legal value.
  always_ff @(posedge clk) begin
    if (rstB) begin
      tens <= '0;
      ones <= '0;
    end else if (inc) begin
      if (ones >= DIGIT_W'(ONES_MAX)) begin
        ones <= '0;
        if (tens >= DIGIT_W'(TENS_MAX)) begin
          tens <= '0;
        end else begin
          tens <= tens + 1'b1;
        end
      end else begin
        ones <= ones + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch core with a divider, a RUN/PAUSED state machine and adjust-mode blink.
// All digit outputs are registered, so a tick shows on the display one clk later.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 500
) (
  input  logic               clk,
  input  logic               rstB,
  input  logic               pause,
  input  logic               sel,
  input  logic               adj,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               paused,
  output logic               blank_min,
  output logic               blank_sec,
  output logic               o_dbg_state
);

  localparam int               DIV_W    = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(TICK_DIV / 2 - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_pause_d;
  run_state_e       r_state;
  logic             r_paused;
  logic             r_blink_phase;

  logic w_tick1;
  logic w_tick2;
  logic w_pause_edge;
  logic w_run_count;
  logic w_sec_inc;
  logic w_min_inc;
  logic w_sec_carry;
  logic w_min_carry;

  always_ff @(posedge clk) begin
    if (rstB) begin
      r_div_cnt <= '0;
    end else if (r_div_cnt == DIV_LAST) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  assign w_tick1 = (r_div_cnt == DIV_LAST);
  assign w_tick2 = (r_div_cnt == DIV_HALF) | w_tick1;

  // pause_d resets high so that a button held through reset does not count as a press.
  always_ff @(posedge clk) begin
    if (rstB) begin
      r_pause_d <= 1'b1;
    end else begin
      r_pause_d <= pause;
    end
  end

  assign w_pause_edge = pause & ~r_pause_d;

  always_ff @(posedge clk) begin
    if (rstB) begin
      r_state  <= RUN;
      r_paused <= 1'b0;
    end else if (w_pause_edge) begin
      case (r_state)
        RUN: begin
          r_state  <= PAUSED;
          r_paused <= 1'b1;
        end
        PAUSED: begin
          r_state  <= RUN;
          r_paused <= 1'b0;
        end
        default: begin
          r_state  <= RUN;
          r_paused <= 1'b0;
        end
      endcase
    end
  end

  // The state read here is the one before any pause edge in this cycle.
  assign w_run_count = ~adj & (r_state == RUN) & w_tick1;
  assign w_sec_inc   = w_run_count | (adj & w_tick2 & sel);
  assign w_min_inc   = (w_run_count & w_sec_carry) | (adj & w_tick2 & ~sel);

  bcd_mod60 u_sec (
    .clk   (clk),
    .rstB  (rstB),
    .inc   (w_sec_inc),
    .tens  (sec_tens),
    .ones  (sec_ones),
    .carry (w_sec_carry)
  );

  bcd_mod60 u_min (
    .clk   (clk),
    .rstB  (rstB),
    .inc   (w_min_inc),
    .tens  (min_tens),
    .ones  (min_ones),
    .carry (w_min_carry)
  );

  always_ff @(posedge clk) begin
    if (rstB || !adj) begin
      r_blink_phase <= 1'b0;
    end else if (w_tick2) begin
      r_blink_phase <= ~r_blink_phase;
    end
  end

  assign paused      = r_paused;
  assign blank_min   = adj & ~sel & r_blink_phase;
  assign blank_sec   = adj & sel & r_blink_phase;
  assign o_dbg_state = r_state;

  // The minute carry has no consumer, because 59:59 simply wraps to 00:00.
  logic w_unused;
  assign w_unused = w_min_carry;

endmodule
